// File: rtl/vc_pop_arbiter_pkg.sv
// vc_pop_arbiter_pkg: arbiter state encodings, default destination bit and VC source tags.
package vc_pop_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;
    localparam int DEST_BIT_DEFAULT = 4;
    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;
endpackage

// File: rtl/vc_route_stage.sv
// vc_route_stage: tracks the in-flight pop, steers the returned word to D0/D1 and counts pushes.
module vc_route_stage
    import vc_pop_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = DEST_BIT_DEFAULT,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 pop_vc0,
    input  logic                 pop_vc1,
    input  logic [DATA_SIZE-1:0] data_vc0,
    input  logic [DATA_SIZE-1:0] data_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic [CNT_SIZE-1:0]  cnt_d0,
    output logic [CNT_SIZE-1:0]  cnt_d1
);
    logic                 tag_valid;
    logic                 tag_vc;
    logic [DATA_SIZE-1:0] word;
    logic                 to_d0;
    logic                 to_d1;

    assign word  = (tag_vc == VC1) ? data_vc1 : data_vc0;
    assign to_d0 = tag_valid & !word[DEST_BIT];
    assign to_d1 = tag_valid & word[DEST_BIT];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            tag_valid <= 1'b0;
            tag_vc    <= VC0;
        end else begin
            tag_valid <= pop_vc0 | pop_vc1;
            tag_vc    <= pop_vc1 ? VC1 : VC0;
        end
    end

    // the word is pushed even if its destination paused meanwhile; the FIFO threshold leaves slack
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_d0 <= 1'b0;
            push_d1 <= 1'b0;
            data_d0 <= '0;
            data_d1 <= '0;
            cnt_d0  <= '0;
            cnt_d1  <= '0;
        end else begin
            push_d0 <= to_d0;
            push_d1 <= to_d1;
            if (to_d0) begin
                data_d0 <= word;
                cnt_d0  <= cnt_d0 + CNT_SIZE'(1);
            end
            if (to_d1) begin
                data_d1 <= word;
                cnt_d1  <= cnt_d1 + CNT_SIZE'(1);
            end
        end
    end
endmodule

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: strict-priority VC0/VC1 pop arbiter feeding the D0/D1 destination FIFOs.
module vc_pop_arbiter
    import vc_pop_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = DEST_BIT_DEFAULT,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 fifo_empty_vc0,
    input  logic                 fifo_empty_vc1,
    input  logic [DATA_SIZE-1:0] data_vc0,
    input  logic [DATA_SIZE-1:0] data_vc1,
    input  logic                 pause_d0,
    input  logic                 pause_d1,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic [CNT_SIZE-1:0]  cnt_d0,
    output logic [CNT_SIZE-1:0]  cnt_d1,
    output logic [1:0]           arb_state
);
    arb_state_t state;
    arb_state_t state_next;
    logic       pause_any;
    logic       any_ready;
    logic       serve;

    // destination is unknown until data returns, so either pause blocks every pop
    assign pause_any = pause_d0 | pause_d1;
    assign any_ready = !fifo_empty_vc0 | !fifo_empty_vc1;
    assign serve     = (state == SERVE) & !pause_any;
    assign pop_vc0   = serve & !fifo_empty_vc0;
    assign pop_vc1   = serve & fifo_empty_vc0 & !fifo_empty_vc1;
    assign arb_state = state;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = pause_any ? ((state == IDLE && !any_ready) ? IDLE : HOLD)
                               : (any_ready ? SERVE : IDLE);
    end

    vc_route_stage #(
        .DATA_SIZE(DATA_SIZE),
        .DEST_BIT (DEST_BIT),
        .CNT_SIZE (CNT_SIZE)
    ) u_route (
        .clk     (clk),
        .reset_L (reset_L),
        .pop_vc0 (pop_vc0),
        .pop_vc1 (pop_vc1),
        .data_vc0(data_vc0),
        .data_vc1(data_vc1),
        .push_d0 (push_d0),
        .push_d1 (push_d1),
        .data_d0 (data_d0),
        .data_d1 (data_d1),
        .cnt_d0  (cnt_d0),
        .cnt_d1  (cnt_d1)
    );
endmodule
